mem_wb_bridge: RTL
==================

MEM_WB_BRIDGE -- requirements
Module: mem_wb_bridge

Interface
REQ-001 SHALL have parameter MEM_AW, default 14, giving the byte-address width of the downstream byte memory (16 KB).
REQ-002 SHALL have port clk, input, 1, the single clock for all state; all sequential logic is rising-edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low (0 = reset).
REQ-004 SHALL have port wb_cyc_i, input, 1, bus cycle valid.
REQ-005 SHALL have port wb_stb_i, input, 1, strobe / request.
REQ-006 SHALL have port wb_we_i, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port wb_adr_i, input, 32, byte address; only [MEM_AW-1:2] is used, and [1:0] is ignored (word aligned).
REQ-008 SHALL have port wb_sel_i, input, 4, byte-lane select; sel[3] = dat[31:24].
REQ-009 SHALL have port wb_dat_i, input, 32, write data.
REQ-010 SHALL have port wb_dat_o, output, 32, registered read data.
REQ-011 SHALL have port wb_ack_o, output, 1, registered single-cycle acknowledge.
REQ-012 SHALL have port mem_adr, output, MEM_AW, byte address to memory.
REQ-013 SHALL have port mem_dat_o, output, 8, byte write data to memory.
REQ-014 SHALL have port mem_dat_i, input, 8, byte read data from memory; valid one cycle after mem_en=1 with mem_we=0, and only while mem_en is still 1 (memory drives Z otherwise).
REQ-015 SHALL have port mem_we, output, 1, memory write enable.
REQ-016 SHALL have port mem_en, output, 1, memory enable.

Function
REQ-017 SHALL implement the FSM states IDLE, XFER, DRAIN and ACK, with a 2-bit byte index k.
REQ-018 In IDLE, SHALL accept a request when wb_cyc_i&wb_stb_i=1 at a clock edge, latching word address, we, sel and data, setting k=0, and moving to XFER.
REQ-019 Byte ordering SHALL be big-endian: byte k uses mem_adr={word,k} and lane dat[31-8k -: 8], with select bit sel[3-k].
REQ-020 Write XFER SHALL drive mem_we=1, mem_en=sel[3-k] and mem_dat_o=lane k, increment k each cycle, and go to ACK after k=3 (4 cycles regardless of sel).
REQ-021 Read XFER SHALL drive mem_en=1 and mem_we=0 for k=0..3 regardless of sel; at each edge ending XFER k≥1, it SHALL capture mem_dat_i into lane k-1; after k=3 it SHALL go to DRAIN.
REQ-022 DRAIN SHALL drive mem_en=1, mem_we=0 and mem_adr={word,3}, capture mem_dat_i into lane 3, and go to ACK.
REQ-023 ACK SHALL drive wb_ack_o=1 for exactly one cycle, with mem_en=0, then go to IDLE; IDLE SHALL not re-accept in the cycle ack is high.
REQ-024 Latency SHALL be: write ack in the 5th cycle after the accepting edge; read ack in the 6th.
REQ-025 wb_dat_o SHALL be updated only by read captures and SHALL hold its value otherwise; writes SHALL not alter it.
REQ-026 Outside XFER/DRAIN, SHALL drive mem_en=0 and mem_we=0; mem_adr and mem_dat_o are don't-care.
REQ-027 If wb_cyc_i=0 at any edge in XFER/DRAIN, SHALL abort to IDLE with no ack; bytes already written remain written.
REQ-028 A write with sel=4'b0000 SHALL take the full 4 cycles with no memory enables and SHALL then ack.
REQ-029 Back-to-back requests SHALL each be accepted in the IDLE cycle following the ACK cycle.

Reset
REQ-030 While rst=0, SHALL force the state to IDLE, k=0, wb_ack_o=0, wb_dat_o=0, mem_en=0, mem_we=0, mem_adr=0 and mem_dat_o=0 immediately, including mid-transfer.
REQ-031 After rst deasserts, SHALL accept a request on the first qualifying edge.

Verification
REQ-032 Write adr 0x2004, sel 1111, dat 0x11223344 -> mem writes 0x2004=11, 0x2005=22, 0x2006=33, 0x2007=44 on consecutive cycles; ack in the 5th cycle.
REQ-033 Read adr 0x2004 after REQ-032 -> mem_en high for 5 cycles; wb_dat_o=0x11223344 with ack in the 6th cycle.
REQ-034 Write adr 0x0100, sel 0100, dat 0xAABBCCDD -> only 0x0101=BB is written (mem_en high once); a readback shows the other bytes unchanged.
REQ-035 Drop wb_cyc_i during write XFER k=2 at adr 0x3FF0 -> bytes 0x3FF0 and 0x3FF1 are written, 0x3FF2 and 0x3FF3 are not, and no ack is issued; the next request completes normally.
REQ-036 Assert rst=0 during read DRAIN -> all outputs are 0 immediately with no ack; after release, a read of 0x2004 returns 0x11223344.

Source files
------------

// File: rtl/mem_wb_bridge.sv
// Wishbone 32-bit slave bridged onto an 8-bit synchronous byte memory.
// Each word moves as four big-endian byte beats; reads take one extra drain cycle.
module mem_wb_bridge #(
   parameter int unsigned MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic [MEM_AW-1:0] mem_adr,
   output logic [7:0]        mem_dat_o,
   input  logic [7:0]        mem_dat_i,
   output logic              mem_we,
   output logic              mem_en
);

   typedef enum logic [1:0] {StIdle, StXfer, StDrain, StAck} state_e;

   state_e            state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic [MEM_AW-3:0] word_q, word_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       wdat_q, wdat_d;
   logic [31:0]       rdat_q, rdat_d;
   logic [31:0]       wshift;
   logic              cap_en;
   logic [1:0]        cap_lane;
   logic              unused_adr;

   assign unused_adr = ^{wb_adr_i[31:MEM_AW], wb_adr_i[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         k_q     <= 2'd0;
         word_q  <= '0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         wdat_q  <= 32'd0;
         rdat_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         word_q  <= word_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      word_d   = word_q;
      we_d     = we_q;
      sel_d    = sel_q;
      wdat_d   = wdat_q;
      cap_en   = 1'b0;
      cap_lane = k_q - 2'd1;
      unique case (state_q)
         StIdle: begin
            if (wb_cyc_i && wb_stb_i) begin
               word_d  = wb_adr_i[MEM_AW-1:2];
               we_d    = wb_we_i;
               sel_d   = wb_sel_i;
               wdat_d  = wb_dat_i;
               k_d     = 2'd0;
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (!wb_cyc_i) begin
               k_d     = 2'd0;
               state_d = StIdle;
            end else begin
               // Read data lags the address by one beat, so beat k lands byte k-1.
               cap_en = !we_q && (k_q != 2'd0);
               k_d    = k_q + 2'd1;
               if (k_q == 2'd3) begin
                  state_d = we_q ? StAck : StDrain;
               end
            end
         end
         StDrain: begin
            k_d = 2'd0;
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else begin
               cap_en   = 1'b1;
               cap_lane = 2'd3;
               state_d  = StAck;
            end
         end
         StAck: begin
            k_d     = 2'd0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rdat_d = rdat_q;
      if (cap_en) begin
         unique case (cap_lane)
            2'd0:    rdat_d[31:24] = mem_dat_i;
            2'd1:    rdat_d[23:16] = mem_dat_i;
            2'd2:    rdat_d[15:8]  = mem_dat_i;
            default: rdat_d[7:0]   = mem_dat_i;
         endcase
      end
   end

   assign wshift = wdat_q << {k_q, 3'b000};

   // Enables are gated by wb_cyc_i so an abandoned cycle touches no further bytes.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_adr   = {word_q, k_q};
      mem_dat_o = wshift[31:24];
      unique case (state_q)
         StXfer: begin
            mem_we = we_q;
            mem_en = wb_cyc_i && (we_q ? sel_q[2'd3 - k_q] : 1'b1);
         end
         StDrain: begin
            mem_en  = wb_cyc_i;
            mem_adr = {word_q, 2'd3};
         end
         default: ;
      endcase
   end

   assign wb_ack_o = (state_q == StAck);
   assign wb_dat_o = rdat_q;

endmodule
